// File: rtl/fpu_share_arbiter_pkg.sv
// Shared FPU definitions used by the arbiter: operand/command widths, the
// flag packing of the FPU wrapper and the issue-slot payload record.
package fpu_share_arbiter_pkg;

   localparam int unsigned C_OP        = 32;
   localparam int unsigned C_CMD       = 4;
   localparam int unsigned C_RM        = 3;
   localparam int unsigned C_FPU_FLAGS = 9;

   // Upper bound on {id, tag}; the top level keeps only ID_W+TAG_W bits of it.
   localparam int unsigned C_TAG_MAX = 16;

   // Flag packing of the FPU wrapper, MSB first: {0, Inf, IV, IX, Zero, 0, 0, UF, OF}.
   typedef struct packed {
      logic rsvd8;
      logic inf;
      logic iv;
      logic ix;
      logic zero;
      logic rsvd3;
      logic rsvd2;
      logic uf;
      logic of;
   } fpu_flags_t;

   // One queued FPU operation as held in the issue slot.
   typedef struct packed {
      logic [C_OP-1:0]      arg_a;
      logic [C_OP-1:0]      arg_b;
      logic [C_CMD-1:0]     op;
      logic [C_RM-1:0]      rm;
      logic [C_TAG_MAX-1:0] tag;
   } fpu_req_t;

endpackage

// File: rtl/fpu_share_arbiter_if.sv
// Bundle of requester-side and FPU-side signals of the shared-FPU arbiter.
// Signal direction suffixes are written from the arbiter's point of view.
interface fpu_share_arbiter_if
   import fpu_share_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned TAG_W   = 4
) ();

   localparam int unsigned ID_W = $clog2(NUM_REQ);

   // Requester side
   logic [NUM_REQ-1:0]                  ReqValid_SI;
   logic [NUM_REQ-1:0]                  ReqReady_SO;
   logic [NUM_REQ-1:0][C_OP-1:0]        ReqArgA_DI;
   logic [NUM_REQ-1:0][C_OP-1:0]        ReqArgB_DI;
   logic [NUM_REQ-1:0][C_CMD-1:0]       ReqOp_SI;
   logic [NUM_REQ-1:0][C_RM-1:0]        ReqRM_SI;
   logic [NUM_REQ-1:0][TAG_W-1:0]       ReqTag_DI;
   logic [NUM_REQ-1:0]                  RespValid_SO;
   logic [C_OP-1:0]                     RespResult_DO;
   logic [C_FPU_FLAGS-1:0]              RespFlags_SO;
   logic [TAG_W-1:0]                    RespTag_DO;

   // FPU side
   logic                                FpuValid_SO;
   logic                                FpuReady_SI;
   logic [C_OP-1:0]                     FpuArgA_DO;
   logic [C_OP-1:0]                     FpuArgB_DO;
   logic [C_CMD-1:0]                    FpuOp_SO;
   logic [C_RM-1:0]                     FpuRM_SO;
   logic [ID_W+TAG_W-1:0]               FpuTag_DO;
   logic                                FpuRespValid_SI;
   logic [C_OP-1:0]                     FpuResult_DI;
   logic [C_FPU_FLAGS-1:0]              FpuFlags_SI;
   logic [ID_W+TAG_W-1:0]               FpuTag_DI;

   logic                                ErrOrphan_SO;

   // Arbiter view
   modport slave (
      input  ReqValid_SI, ReqArgA_DI, ReqArgB_DI, ReqOp_SI, ReqRM_SI, ReqTag_DI,
      input  FpuReady_SI, FpuRespValid_SI, FpuResult_DI, FpuFlags_SI, FpuTag_DI,
      output ReqReady_SO, RespValid_SO, RespResult_DO, RespFlags_SO, RespTag_DO,
      output FpuValid_SO, FpuArgA_DO, FpuArgB_DO, FpuOp_SO, FpuRM_SO, FpuTag_DO,
      output ErrOrphan_SO
   );

   // Environment view (requesters plus FPU wrapper)
   modport master (
      output ReqValid_SI, ReqArgA_DI, ReqArgB_DI, ReqOp_SI, ReqRM_SI, ReqTag_DI,
      output FpuReady_SI, FpuRespValid_SI, FpuResult_DI, FpuFlags_SI, FpuTag_DI,
      input  ReqReady_SO, RespValid_SO, RespResult_DO, RespFlags_SO, RespTag_DO,
      input  FpuValid_SO, FpuArgA_DO, FpuArgB_DO, FpuOp_SO, FpuRM_SO, FpuTag_DO,
      input  ErrOrphan_SO
   );

endinterface

// File: rtl/fpu_rr_arb.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping modulo NUM_REQ. Pointer update is left to the instantiating block.
module fpu_rr_arb #(
   parameter  int unsigned NUM_REQ = 4,
   localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [ID_W-1:0]    idx,
   output logic               valid
);

   int unsigned       p;
   logic [ID_W-1:0]   pos;

   // Scan NUM_REQ positions starting at ptr and keep the first hit.
   always_comb begin
      gnt   = '0;
      idx   = '0;
      valid = 1'b0;
      p     = 0;
      pos   = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         p = 32'(ptr) + i;
         if (p >= NUM_REQ) begin
            p = p - NUM_REQ;
         end
         pos = ID_W'(p);
         if (!valid && req[pos]) begin
            valid    = 1'b1;
            gnt[pos] = 1'b1;
            idx      = pos;
         end
      end
   end

endmodule

// File: rtl/fpu_share_arbiter.sv
// Shares one FPU between NUM_REQ requesters: round-robin grant into a
// registered issue slot, caps operations in flight, and steers each result
// back to its requester through a registered one-hot demux.
module fpu_share_arbiter
   import fpu_share_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ         = 4,
   parameter int unsigned TAG_W           = 4,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input logic                  Clk_CI,
   input logic                  Rst_RI,
   fpu_share_arbiter_if.slave   bus
);

   localparam int unsigned ID_W   = $clog2(NUM_REQ);
   localparam int unsigned FTAG_W = ID_W + TAG_W;
   localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING + 1);

   logic [ID_W-1:0]    ptr_q;
   logic [ID_W-1:0]    arb_idx;
   logic [NUM_REQ-1:0] arb_gnt;
   logic               arb_valid;

   fpu_req_t           slot_q, slot_d;
   logic               slot_valid_q;
   logic               issue_fire, slot_free, can_grant, grant;

   logic [CNT_W-1:0]   inflight_q, inflight_d;

   logic [ID_W-1:0]    rsp_id;
   logic               rsp_orphan, rsp_ok;
   logic [NUM_REQ-1:0] rsp_onehot;

   logic [NUM_REQ-1:0] resp_valid_q;
   logic [C_OP-1:0]    resp_result_q;
   fpu_flags_t         resp_flags_q;
   logic [TAG_W-1:0]   resp_tag_q;
   logic               err_q;

   logic               unused_tag_hi;

   fpu_rr_arb #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_arb (
      .req   (bus.ReqValid_SI),
      .ptr   (ptr_q),
      .gnt   (arb_gnt),
      .idx   (arb_idx),
      .valid (arb_valid)
   );

   // Grant qualification: slot free (empty or draining now) and room for one more op.
   always_comb begin
      issue_fire = slot_valid_q && bus.FpuReady_SI;
      slot_free  = !slot_valid_q || issue_fire;
      can_grant  = !Rst_RI && slot_free && (inflight_q < CNT_W'(MAX_OUTSTANDING));
      grant      = can_grant && arb_valid;
   end

   // Payload of the winning requester, tagged with its index.
   always_comb begin
      slot_d       = '0;
      slot_d.arg_a = bus.ReqArgA_DI[arb_idx];
      slot_d.arg_b = bus.ReqArgB_DI[arb_idx];
      slot_d.op    = bus.ReqOp_SI[arb_idx];
      slot_d.rm    = bus.ReqRM_SI[arb_idx];
      slot_d.tag   = C_TAG_MAX'({arb_idx, bus.ReqTag_DI[arb_idx]});
   end

   // Response classification and inflight bookkeeping.
   always_comb begin
      rsp_id     = bus.FpuTag_DI[FTAG_W-1:TAG_W];
      rsp_orphan = bus.FpuRespValid_SI && ((inflight_q == '0) || (32'(rsp_id) >= NUM_REQ));
      rsp_ok     = bus.FpuRespValid_SI && !rsp_orphan;
      rsp_onehot = '0;
      if (rsp_ok) begin
         rsp_onehot[rsp_id] = 1'b1;
      end
      case ({grant, rsp_ok})
         2'b10:   inflight_d = inflight_q + CNT_W'(1);
         2'b01:   inflight_d = inflight_q - CNT_W'(1);
         default: inflight_d = inflight_q;
      endcase
   end

   // Issue slot, round-robin pointer and inflight counter.
   always_ff @(posedge Clk_CI) begin
      if (Rst_RI) begin
         slot_q       <= '0;
         slot_valid_q <= 1'b0;
         ptr_q        <= '0;
         inflight_q   <= '0;
      end else begin
         inflight_q <= inflight_d;
         if (grant) begin
            slot_q       <= slot_d;
            slot_valid_q <= 1'b1;
            ptr_q        <= (32'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + ID_W'(1);
         end else if (issue_fire) begin
            slot_valid_q <= 1'b0;
         end
      end
   end

   // Registered response demux and sticky orphan flag.
   always_ff @(posedge Clk_CI) begin
      if (Rst_RI) begin
         resp_valid_q  <= '0;
         resp_result_q <= '0;
         resp_flags_q  <= '0;
         resp_tag_q    <= '0;
         err_q         <= 1'b0;
      end else begin
         resp_valid_q <= rsp_onehot;
         if (rsp_ok) begin
            resp_result_q <= bus.FpuResult_DI;
            resp_flags_q  <= fpu_flags_t'(bus.FpuFlags_SI);
            resp_tag_q    <= bus.FpuTag_DI[TAG_W-1:0];
         end
         if (rsp_orphan) begin
            err_q <= 1'b1;
         end
      end
   end

   // Bits of the slot tag above {id, tag} are always zero.
   assign unused_tag_hi = ^slot_q.tag[C_TAG_MAX-1:FTAG_W];

   assign bus.ReqReady_SO   = grant ? arb_gnt : '0;
   assign bus.FpuValid_SO   = slot_valid_q;
   assign bus.FpuArgA_DO    = slot_q.arg_a;
   assign bus.FpuArgB_DO    = slot_q.arg_b;
   assign bus.FpuOp_SO      = slot_q.op;
   assign bus.FpuRM_SO      = slot_q.rm;
   assign bus.FpuTag_DO     = slot_q.tag[FTAG_W-1:0];
   assign bus.RespValid_SO  = resp_valid_q;
   assign bus.RespResult_DO = resp_result_q;
   assign bus.RespFlags_SO  = resp_flags_q;
   assign bus.RespTag_DO    = resp_tag_q;
   assign bus.ErrOrphan_SO  = err_q;

endmodule

// File: tb/tb_fpu_share_arbiter.sv
// Directed bench for fpu_share_arbiter: a cycle table for arbitration, limit
// and routing, plus hand-written sequences for reset, backpressure and orphans.
module tb_fpu_share_arbiter;
   import fpu_share_arbiter_pkg::*;

   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned TAG_W   = 4;
   localparam int unsigned MAX_OUT = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;
   int   g;

   always #5 clk = ~clk;

   fpu_share_arbiter_if #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) bus ();

   fpu_share_arbiter #(
      .NUM_REQ         (NUM_REQ),
      .TAG_W           (TAG_W),
      .MAX_OUTSTANDING (MAX_OUT)
   ) dut (
      .Clk_CI (clk),
      .Rst_RI (rst),
      .bus    (bus)
   );

   typedef struct {
      logic [3:0] req;
      logic       rdy;
      logic       rsp;
      logic [1:0] rid;
      logic [3:0] gnt;
      logic       fv;
      logic [3:0] rspv;
      logic [1:0] fid;
   } vec_t;

   vec_t vecs [13];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [3:0] req, input logic rdy, input logic rsp,
                         input logic [5:0] rtag);
      bus.ReqValid_SI     = req;
      bus.FpuReady_SI     = rdy;
      bus.FpuRespValid_SI = rsp;
      bus.FpuTag_DI       = rtag;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      set_in(4'h0, 1'b0, 1'b0, 6'h0);
      cyc();
      cyc();
      rst = 1'b0;
   endtask

   function automatic logic [5:0] exp_tag(input int k);
      return {2'(k), 4'(5 + 3 * k)};
   endfunction

   initial begin
      // Fixed per-requester payloads
      for (int k = 0; k < 4; k++) begin
         bus.ReqArgA_DI[k] = 32'h1000_0000 + 32'(k);
         bus.ReqArgB_DI[k] = 32'h2000_0000 + 32'(k);
         bus.ReqOp_SI[k]   = 4'(k + 1);
         bus.ReqRM_SI[k]   = 3'(k);
         bus.ReqTag_DI[k]  = 4'(5 + 3 * k);
      end
      bus.FpuResult_DI = 32'h0;
      bus.FpuFlags_SI  = '0;

      // req, rdy, rsp, rid, expected grant, FpuValid, RespValid, slot id
      vecs[0]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b0, 4'b0000, 2'd0};
      vecs[1]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b0010, 1'b1, 4'b0000, 2'd0};
      vecs[2]  = '{4'b1111, 1'b1, 1'b1, 2'd0, 4'b0100, 1'b1, 4'b0000, 2'd1};
      vecs[3]  = '{4'b1010, 1'b1, 1'b1, 2'd1, 4'b1000, 1'b1, 4'b0001, 2'd2};
      vecs[4]  = '{4'b1010, 1'b1, 1'b0, 2'd0, 4'b0010, 1'b1, 4'b0010, 2'd3};
      vecs[5]  = '{4'b1010, 1'b1, 1'b0, 2'd0, 4'b1000, 1'b1, 4'b0000, 2'd1};
      vecs[6]  = '{4'b1111, 1'b1, 1'b1, 2'd2, 4'b0000, 1'b1, 4'b0000, 2'd3};
      vecs[7]  = '{4'b1111, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b0, 4'b0100, 2'd0};
      vecs[8]  = '{4'b0100, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000, 2'd0};
      vecs[9]  = '{4'b0100, 1'b0, 1'b1, 2'd3, 4'b0000, 1'b1, 4'b0000, 2'd0};
      vecs[10] = '{4'b0100, 1'b1, 1'b0, 2'd0, 4'b0100, 1'b1, 4'b1000, 2'd0};
      vecs[11] = '{4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000, 2'd2};
      vecs[12] = '{4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000, 2'd0};

      // Reset held two cycles with all requests up
      rst = 1'b1;
      set_in(4'hF, 1'b1, 1'b0, 6'h0);
      for (int c = 0; c < 2; c++) begin
         cyc();
         chk($sformatf("rst%0d_ready", c), 64'(bus.ReqReady_SO), 64'h0);
         chk($sformatf("rst%0d_outputs", c),
             64'(|{bus.RespValid_SO, bus.RespResult_DO, bus.RespFlags_SO, bus.RespTag_DO,
                   bus.FpuValid_SO, bus.FpuArgA_DO, bus.FpuArgB_DO, bus.FpuOp_SO,
                   bus.FpuRM_SO, bus.FpuTag_DO, bus.ErrOrphan_SO}), 64'h0);
      end
      rst = 1'b0;

      // Table: arbitration order, limit fill, backpressure and routing
      for (int i = 0; i < 13; i++) begin
         set_in(vecs[i].req, vecs[i].rdy, vecs[i].rsp, {vecs[i].rid, 4'h0});
         #1;
         chk($sformatf("vec%0d_ready", i), 64'(bus.ReqReady_SO), 64'(vecs[i].gnt));
         chk($sformatf("vec%0d_fvalid", i), 64'(bus.FpuValid_SO), 64'(vecs[i].fv));
         chk($sformatf("vec%0d_respvalid", i), 64'(bus.RespValid_SO), 64'(vecs[i].rspv));
         if (vecs[i].fv) begin
            chk($sformatf("vec%0d_ftag", i), 64'(bus.FpuTag_DO), 64'(exp_tag(int'(vecs[i].fid))));
            chk($sformatf("vec%0d_arga", i), 64'(bus.FpuArgA_DO),
                64'(32'h1000_0000 + 32'(vecs[i].fid)));
         end
         cyc();
      end

      // Backpressure then response routing
      do_reset();
      set_in(4'b0001, 1'b0, 1'b0, 6'h0);
      #1;
      chk("bp_first_grant", 64'(bus.ReqReady_SO), 64'b0001);
      cyc();
      for (int c = 0; c < 5; c++) begin
         set_in(4'b0010, 1'b0, 1'b0, 6'h0);
         #1;
         chk($sformatf("bp%0d_fvalid", c), 64'(bus.FpuValid_SO), 64'h1);
         chk($sformatf("bp%0d_ftag", c), 64'(bus.FpuTag_DO), 64'(exp_tag(0)));
         chk($sformatf("bp%0d_arga", c), 64'(bus.FpuArgA_DO), 64'h1000_0000);
         chk($sformatf("bp%0d_ready", c), 64'(bus.ReqReady_SO), 64'h0);
         cyc();
      end
      set_in(4'b0010, 1'b1, 1'b0, 6'h0);
      #1;
      chk("bp_release_grant", 64'(bus.ReqReady_SO), 64'b0010);
      cyc();
      set_in(4'b0000, 1'b1, 1'b1, {2'd2, 4'hA});
      bus.FpuResult_DI = 32'h3F80_0000;
      bus.FpuFlags_SI  = 9'h0A0;
      #1;
      chk("bp_second_ftag", 64'(bus.FpuTag_DO), 64'(exp_tag(1)));
      cyc();
      set_in(4'b0000, 1'b0, 1'b0, 6'h0);
      #1;
      chk("route_valid", 64'(bus.RespValid_SO), 64'b0100);
      chk("route_tag", 64'(bus.RespTag_DO), 64'hA);
      chk("route_result", 64'(bus.RespResult_DO), 64'h3F80_0000);
      chk("route_flags", 64'(bus.RespFlags_SO), 64'h0A0);
      cyc();
      #1;
      chk("route_one_cycle", 64'(bus.RespValid_SO), 64'h0);
      chk("route_no_orphan", 64'(bus.ErrOrphan_SO), 64'h0);
      cyc();

      // Outstanding limit, FPU silent
      do_reset();
      g = 0;
      for (int c = 0; c < 8; c++) begin
         set_in(4'hF, 1'b1, 1'b0, 6'h0);
         #1;
         if (|bus.ReqReady_SO) g++;
         cyc();
      end
      chk("limit_grants", 64'(g), 64'(MAX_OUT));
      set_in(4'hF, 1'b1, 1'b1, {2'd0, 4'h5});
      #1;
      chk("limit_resp_cycle_ready", 64'(bus.ReqReady_SO), 64'h0);
      cyc();
      set_in(4'hF, 1'b1, 1'b0, 6'h0);
      #1;
      chk("limit_resume_ready", 64'(bus.ReqReady_SO), 64'b0001);
      chk("limit_resp_valid", 64'(bus.RespValid_SO), 64'b0001);
      cyc();
      #1;
      chk("limit_full_again", 64'(bus.ReqReady_SO), 64'h0);
      cyc();

      // Orphan response with nothing in flight
      do_reset();
      set_in(4'h0, 1'b0, 1'b1, {2'd1, 4'h3});
      #1;
      chk("orph_err_before", 64'(bus.ErrOrphan_SO), 64'h0);
      cyc();
      set_in(4'h0, 1'b0, 1'b0, 6'h0);
      #1;
      chk("orph_no_valid", 64'(bus.RespValid_SO), 64'h0);
      chk("orph_err_set", 64'(bus.ErrOrphan_SO), 64'h1);
      cyc();
      g = 0;
      for (int c = 0; c < 8; c++) begin
         set_in(4'hF, 1'b1, 1'b0, 6'h0);
         #1;
         if (|bus.ReqReady_SO) g++;
         cyc();
      end
      chk("orph_inflight_zero", 64'(g), 64'(MAX_OUT));
      chk("orph_err_held", 64'(bus.ErrOrphan_SO), 64'h1);
      do_reset();
      #1;
      chk("orph_err_cleared", 64'(bus.ErrOrphan_SO), 64'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
